store_lane_packer: RTL and testbench

Store-path formatter and buffer for the MIPS datapath: the narrowing counterpart of the immediate/load-side sign/zero extension. It accepts 32-bit register data with a byte address and access size (SB/SH/SW), packs the data onto the correct byte lanes with a 4-bit byte-enable, and queues the result in a small FIFO. A valid/ready handshake drains the FIFO to data memory, so the pipeline need not stall on every store.

---
 rtl/store_lane_packer.sv | 117 +++++++++++
 tb/tb_store_lane_packer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/store_lane_packer.sv
// Store-path lane packer and FIFO: formats SB/SH/SW data onto byte lanes and queues it for data memory.
// Optional misalignment trap enabled by defining STORE_MISALIGN_TRAP_EN.
module store_lane_packer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        empty,
  output logic        err_valid,
  output logic [31:0] err_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [29:0]   addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [3:0]    be_mem   [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic [31:0] pk_wdata;
  logic [3:0]  pk_be;
  logic        accept, drain, wr_en;

  assign accept = req_valid & req_ready;
  assign drain  = mem_valid & mem_ready;

  always_comb begin
    pk_wdata = req_data;
    pk_be    = 4'b1111;
    case (req_size)
      2'b00: begin
        pk_wdata = {4{req_data[7:0]}};
        pk_be    = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        pk_wdata = {2{req_data[15:0]}};
        pk_be    = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        pk_wdata = req_data;
        pk_be    = 4'b1111;
      end
    endcase
  end

`ifdef STORE_MISALIGN_TRAP_EN
  logic misaligned;

  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
  // Misaligned requests complete the handshake but never reach the queue.
  assign wr_en = accept & ~misaligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else begin
      err_valid <= accept & misaligned;
      if (accept && misaligned)
        err_addr <= req_addr;
    end
  end
`else
  assign wr_en     = accept;
  assign err_valid = 1'b0;
  assign err_addr  = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + PW'(1);
      if (drain)
        rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy is tracked solely by count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      addr_mem[wr_ptr] <= req_addr[31:2];
      data_mem[wr_ptr] <= pk_wdata;
      be_mem[wr_ptr]   <= pk_be;
    end
  end

  assign mem_valid = (count != '0);
  assign empty     = (count == '0);
  assign req_ready = (count != FULL);
  assign mem_addr  = {addr_mem[rd_ptr], 2'b00};
  assign mem_wdata = data_mem[rd_ptr];
  assign mem_be    = mem_valid ? be_mem[rd_ptr] : 4'b0000;

endmodule

// File: tb/tb_store_lane_packer.sv
// Scoreboard bench for store_lane_packer: directed stores push expected memory writes,
// a monitor pops and compares each write the DUT hands to memory.
module tb_store_lane_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        empty;
  logic        err_valid;
  logic [31:0] err_addr;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } wr_t;

  wr_t exp_q[$];
  int checks = 0;
  int errors = 0;

  store_lane_packer #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .empty(empty), .err_valid(err_valid), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer one request until accepted (bounded), optionally recording its expected write.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                      input bit exp_write, input logic [31:0] ea, input logic [31:0] ed,
                      input logic [3:0] eb);
    wr_t e;
    bit  done = 0;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
    req_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (req_ready) begin
        if (exp_write) begin
          e.addr = ea; e.wdata = ed; e.be = eb;
          exp_q.push_back(e);
        end
        done = 1;
      end
      tick();
    end
    req_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 for addr %h", a);
    end
  endtask

  // Monitor: samples on the falling edge, i.e. the values the next rising edge will see.
  always @(negedge clk) begin
    if (!rst && mem_valid && mem_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h wdata %h be %b expected none",
                 mem_addr, mem_wdata, mem_be);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("drain_addr", mem_addr, e.addr);
        check("drain_wdata", mem_wdata, e.wdata);
        check("drain_be", {28'd0, mem_be}, {28'd0, e.be});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
    mem_ready = 1'b0;
    tick(); tick();
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_mem_be", {28'd0, mem_be}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_err_valid", {31'd0, err_valid}, 32'd0);
    check("rst_err_addr", err_addr, 32'd0);
    rst = 1'b0;
    tick();

    // SB at 0x1003: presented one cycle after accept
    check("sb_pre_valid", {31'd0, mem_valid}, 32'd0);
    send(32'h0000_1003, 32'h1234_56A5, 2'b00, 1, 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000);
    check("sb_latency_valid", {31'd0, mem_valid}, 32'd1);
    check("sb_be_direct", {28'd0, mem_be}, 32'h8);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("sb_empty_after", {31'd0, empty}, 32'd1);

    // SH then SW back-to-back with memory always ready
    mem_ready = 1'b1;
    send(32'h0000_2002, 32'hFFFF_BEEF, 2'b01, 1, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100);
    check("sh_presented", mem_addr, 32'h0000_2000);
    send(32'h0000_2004, 32'hCAFE_F00D, 2'b10, 1, 32'h0000_2004, 32'hCAFE_F00D, 4'b1111);
    check("sw_no_bubble_valid", {31'd0, mem_valid}, 32'd1);
    check("sw_no_bubble_addr", mem_addr, 32'h0000_2004);
    tick();
    check("shsw_empty", {31'd0, empty}, 32'd1);
    mem_ready = 1'b0;

    // Backpressure: two accepted, third blocked until a slot frees
    send(32'h0000_4000, 32'h1111_1111, 2'b10, 1, 32'h0000_4000, 32'h1111_1111, 4'b1111);
    send(32'h0000_4005, 32'h0000_0022, 2'b00, 1, 32'h0000_4004, 32'h2222_2222, 4'b0010);
    req_addr = 32'h0000_4008; req_data = 32'h0000_3333; req_size = 2'b01; req_valid = 1'b1;
    check("bp_full_ready", {31'd0, req_ready}, 32'd0);
    tick(); tick();
    check("bp_hold_ready", {31'd0, req_ready}, 32'd0);
    check("bp_hold_addr", mem_addr, 32'h0000_4000);
    check("bp_hold_wdata", mem_wdata, 32'h1111_1111);
    check("bp_hold_be", {28'd0, mem_be}, 32'hF);
    mem_ready = 1'b1;
    req_valid = 1'b0;
    send(32'h0000_4008, 32'h0000_3333, 2'b01, 1, 32'h0000_4008, 32'h3333_3333, 4'b0011);
    tick(); tick();
    check("bp_empty", {31'd0, empty}, 32'd1);
    mem_ready = 1'b0;

    // Fill, then stream 8 words with memory ready: order and count preserved
    send(32'h0000_5000, 32'hB000_0000, 2'b11, 1, 32'h0000_5000, 32'hB000_0000, 4'b1111);
    send(32'h0000_5006, 32'h0000_00B1, 2'b00, 1, 32'h0000_5004, 32'hB1B1_B1B1, 4'b0100);
    check("stream_full", {31'd0, req_ready}, 32'd0);
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      logic [31:0] d;
      a = 32'h0000_6000 + 32'(i) * 4;
      d = 32'hA000_0000 + 32'(i);
      send(a, d, 2'b10, 1, a, d, 4'b1111);
      check("stream_nonempty", {31'd0, empty}, 32'd0);
    end
    tick(); tick();
    check("stream_empty", {31'd0, empty}, 32'd1);
    mem_ready = 1'b0;

    // Reset with two stores queued discards them
    send(32'h0000_7000, 32'h7777_7777, 2'b10, 0, '0, '0, '0);
    send(32'h0000_7004, 32'h8888_8888, 2'b10, 0, '0, '0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_mid_be", {28'd0, mem_be}, 32'd0);
    check("rst_mid_empty", {31'd0, empty}, 32'd1);
    mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;

    // Misaligned halfword at 0x3001
`ifdef STORE_MISALIGN_TRAP_EN
    check("mis_err_pre", {31'd0, err_valid}, 32'd0);
    send(32'h0000_3001, 32'h0000_5A5A, 2'b01, 0, '0, '0, '0);
    check("mis_err_valid", {31'd0, err_valid}, 32'd1);
    check("mis_err_addr", err_addr, 32'h0000_3001);
    check("mis_not_queued", {31'd0, empty}, 32'd1);
    tick();
    check("mis_err_pulse", {31'd0, err_valid}, 32'd0);
`else
    send(32'h0000_3001, 32'h0000_5A5A, 2'b01, 1, 32'h0000_3000, 32'h5A5A_5A5A, 4'b0011);
    check("mis_no_err", {31'd0, err_valid}, 32'd0);
    check("mis_queued", {31'd0, mem_valid}, 32'd1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
`endif
    tick();
    check("all_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
